// File: rtl/gol_gen_sequencer_if.sv
// Host write port and register-file access bus of the Game-of-Life generation sequencer.
// Host handshake: host_req is held with host_wa/host_wd stable until host_ack is seen; host_ack
// is combinational and means the write is presented to the file in this cycle.
interface gol_gen_sequencer_if #(
   parameter int WIDTH   = 8,
   parameter int REGBITS = 3
);
   logic               host_req;
   logic [REGBITS-1:0] host_wa;
   logic [WIDTH-1:0]   host_wd;
   logic               host_ack;
   logic [REGBITS-1:0] ra;
   logic [WIDTH-1:0]   rd;
   logic [REGBITS-1:0] wa;
   logic [WIDTH-1:0]   wd;
   logic               regwrite;

   modport master (
      input  host_req, host_wa, host_wd, rd,
      output host_ack, ra, wa, wd, regwrite
   );

   modport slave (
      output host_req, host_wa, host_wd, rd,
      input  host_ack, ra, wa, wd, regwrite
   );
endinterface

// File: rtl/gol_gen_sequencer.sv
// Reads the board into a snapshot, writes the next Game-of-Life generation back row by row,
// and arbitrates the register-file write port for host loads while idle.
module gol_gen_sequencer #(
   parameter int WIDTH   = 8,
   parameter int REGBITS = 3,
   parameter int TORUS   = 0
) (
   input  logic                 ph2,
   input  logic                 reset,
   input  logic                 start,
   gol_gen_sequencer_if.master  bus,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          gen_count,
   output logic                 stable,
   output logic                 extinct,
   output logic [1:0]           o_dbg_state
);
   localparam int ROWS = 2 ** REGBITS;
   localparam logic [REGBITS-1:0] ROW_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [REGBITS-1:0] r_row;
   logic [WIDTH-1:0]   r_snap [ROWS];
   logic               r_diff;
   logic               r_any;
   logic [15:0]        r_gen_count;
   logic               r_stable;
   logic               r_extinct;

   logic [REGBITS-1:0] w_row_up;
   logic [REGBITS-1:0] w_row_dn;
   logic               w_last_row;
   logic [WIDTH-1:0]   w_up, w_cur, w_dn;
   logic [WIDTH-1:0]   w_ul, w_ur, w_cl, w_cr, w_dl, w_dr;
   logic [WIDTH-1:0]   w_next;
   logic [3:0]         w_cnt;

   // Bit c of the result holds the neighbour in column c-1 (shl) or c+1 (shr).
   function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] x);
      shl = {x[WIDTH-2:0], (TORUS != 0) ? x[WIDTH-1] : 1'b0};
   endfunction

   function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] x);
      shr = {(TORUS != 0) ? x[0] : 1'b0, x[WIDTH-1:1]};
   endfunction

   assign w_row_up   = r_row - ROW_ONE;
   assign w_row_dn   = r_row + ROW_ONE;
   assign w_last_row = (r_row == '1);

   always_comb begin
      w_cur = r_snap[r_row];
      w_up  = r_snap[w_row_up];
      w_dn  = r_snap[w_row_dn];
      if (TORUS == 0 && r_row == '0) w_up = '0;
      if (TORUS == 0 && r_row == '1) w_dn = '0;
   end

   assign w_ul = shl(w_up);
   assign w_ur = shr(w_up);
   assign w_cl = shl(w_cur);
   assign w_cr = shr(w_cur);
   assign w_dl = shl(w_dn);
   assign w_dr = shr(w_dn);

   always_comb begin
      w_next = '0;
      w_cnt  = '0;
      for (int c = 0; c < WIDTH; c++) begin
         w_cnt = {3'b000, w_ul[c]} + {3'b000, w_up[c]} + {3'b000, w_ur[c]}
               + {3'b000, w_cl[c]} + {3'b000, w_cr[c]}
               + {3'b000, w_dl[c]} + {3'b000, w_dn[c]} + {3'b000, w_dr[c]};
         w_next[c] = (w_cnt == 4'd3) || (w_cur[c] && w_cnt == 4'd2);
      end
   end

   always_ff @(posedge ph2 or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      bus.ra       = '0;
      bus.wa       = '0;
      bus.wd       = '0;
      bus.regwrite = 1'b0;
      bus.host_ack = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_READ;
            end else if (bus.host_req && reset) begin
               // Gated by reset so a held host request cannot write while the block is in reset.
               bus.regwrite = 1'b1;
               bus.wa       = bus.host_wa;
               bus.wd       = bus.host_wd;
               bus.host_ack = 1'b1;
            end
         end
         S_READ: begin
            busy   = 1'b1;
            bus.ra = r_row;
            if (w_last_row) w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            busy         = 1'b1;
            bus.regwrite = 1'b1;
            bus.wa       = r_row;
            bus.wd       = w_next;
            if (w_last_row) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ph2 or negedge reset) begin
      if (!reset) begin
         r_row       <= '0;
         r_diff      <= 1'b0;
         r_any       <= 1'b0;
         r_gen_count <= '0;
         r_stable    <= 1'b0;
         r_extinct   <= 1'b0;
         for (int i = 0; i < ROWS; i++) r_snap[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_row  <= '0;
                  r_diff <= 1'b0;
                  r_any  <= 1'b0;
               end
            end
            S_READ: begin
               r_snap[r_row] <= bus.rd;
               r_row         <= r_row + ROW_ONE;
            end
            S_WRITE: begin
               r_diff <= r_diff | (w_next != w_cur);
               r_any  <= r_any | (|w_next);
               r_row  <= r_row + ROW_ONE;
            end
            S_DONE: begin
               r_gen_count <= r_gen_count + 16'd1;
               r_stable    <= !r_diff;
               r_extinct   <= !r_any;
            end
            default: ;
         endcase
      end
   end

   assign gen_count   = r_gen_count;
   assign stable      = r_stable;
   assign extinct     = r_extinct;
   assign o_dbg_state = r_state;
endmodule

// File: doc/gol_gen_sequencer.md
# gol_gen_sequencer

Generation sequencer for the Game-of-Life board held in the 8×8 current-state register file. On each `start` it reads every row out through the file's read port, computes the next generation in a local 64-bit snapshot, then writes all rows back through the file's write port. While idle, it arbitrates the write port so a host can load patterns. It also reports a generation count and `stable`/`extinct` status.

## Interface
- `WIDTH`, 8: cells per row; bit *c* of a row is column *c*.
- `REGBITS`, 3: row address width; the board has 2**REGBITS rows.
- `TORUS`, 0: 0 means cells outside the board are dead; 1 means rows and columns wrap around.
- `ph2`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; a low level forces the reset state immediately.
- `start`  in  1  request one generation; sampled only in IDLE.
- `host_req`  in  1  host write request.
- `host_wa`  in  REGBITS  host write row.
- `host_wd`  in  WIDTH  host write data.
- `host_ack`  out  1  host write performed this cycle.
- `ra`  out  REGBITS  register-file read address.
- `rd`  in  WIDTH  register-file read data (combinational from `ra`).
- `wa`  out  REGBITS  register-file write address.
- `wd`  out  WIDTH  register-file write data.
- `regwrite`  out  1  register-file write enable.
- `busy`  out  1  sequencer is in READ, WRITE or DONE.
- `done`  out  1  one-cycle pulse when a generation completes.
- `gen_count`  out  16  number of completed generations.
- `stable`  out  1  the last generation equalled its predecessor.
- `extinct`  out  1  the last generation was all-zero.

## Operation
- States: IDLE, READ, WRITE, DONE. A row counter `row` (REGBITS bits) runs in READ and WRITE.
- IDLE:
  - `ra`=0 and `busy`=0.
  - If `start`=1: go to READ with `row`=0.
  - Otherwise, if `host_req`=1: drive `regwrite`=1, `wa`=`host_wa`, `wd`=`host_wd`, `host_ack`=1 in the same cycle (combinational pass-through).
  - If `start` and `host_req` are both high: `start` wins and `host_ack`=0. The host must hold `host_req`.
- READ:
  - `ra`=`row`. At the clock edge, `snap[row]` captures `rd`.
  - `row` increments. After row 2**REGBITS−1, go to WRITE with `row`=0.
  - `host_ack`=0 and `regwrite`=0.
- WRITE:
  - `regwrite`=1, `wa`=`row`, `wd`=`next(row)`.
  - `next` is computed combinationally from the frozen `snap`.
  - After the last row, go to DONE.
- Next-state rule per cell:
  - Count the 8 neighbours (3-bit sum plus carry; maximum 8).
  - A live cell survives on 2 or 3 neighbours.
  - A dead cell is born on exactly 3.
  - Edge handling follows `TORUS`.
- Status accumulated during WRITE:
  - `diff` is the OR of (`next(row)` ≠ `snap[row]`).
  - `any` is the OR of `next(row)`.
- DONE:
  - `done`=1 for one cycle. Then go to IDLE.
  - `gen_count` increments, wrapping 0xFFFF→0.
  - `stable` ← !`diff` and `extinct` ← !`any`; both hold until the next DONE.
- `start` pulses while `busy` are ignored.
- `snap` is never written in WRITE, so a host cannot corrupt a generation in progress. Host writes are blocked while `busy`.

## Timing
- Reset values: state IDLE, `row`=0, `ra`=0, `wa`=0, `wd`=0, `regwrite`=0, `host_ack`=0, `busy`=0, `done`=0, `gen_count`=0, `stable`=0, `extinct`=0, `snap`=0.
- `start` sampled high at edge k:
  - READ occupies cycles k+1 … k+R, where R=2**REGBITS.
  - WRITE occupies k+R+1 … k+2R.
  - DONE is cycle k+2R+1; `done` is high in that cycle.
  - IDLE resumes at k+2R+2. With defaults, `done` comes 17 cycles after the `start` edge.
- `busy` is high in every READ, WRITE and DONE cycle.
- `gen_count`, `stable` and `extinct` change at the edge ending DONE.
- Host write latency: zero cycles, gated in IDLE only. The file commits the write on its own write edge.
- Reset asserted mid-operation:
  - The machine returns to IDLE immediately and `regwrite` drops asynchronously.
  - Rows already written keep their new values; no rollback.
- Back-to-back: `start` held high re-triggers at the first IDLE cycle, so the period is 2R+2 cycles.

## Test plan
- Reset, then 10 idle cycles with no `start` -> `regwrite`=0, `busy`=0 and all outputs at reset values throughout.
- Host writes rows 1, 2, 3 = 0x08, then `start` -> writes rows 0–7 = {0,0,0x1C,0,0,0,0,0}, `done` at cycle 17, `gen_count`=1, `stable`=0, `extinct`=0. A second `start` restores the vertical blinker.
- 2×2 block: rows 4, 5 = 0x03, then `start` -> identical rows written back, `stable`=1, `extinct`=0.
- Single cell, row 3 = 0x10, then `start` -> all rows 0, `extinct`=1. A further `start` gives `stable`=1.
- Row 0 = 0x07 with `TORUS`=0 -> rows 0, 1 = 0x02, rest 0. Same pattern with `TORUS`=1 -> rows 7, 0, 1 = 0x02.
- Mid-run cases:
  - `host_req` raised during WRITE -> `host_ack`=0 until IDLE, then 1.
  - `reset` pulsed low at cycle 12 after `start` -> `regwrite` drops at once, `busy`=0, `gen_count` unchanged.
